// File: rtl/pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA BAR-read completion path.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW_WIDTH    = 32;
  localparam int unsigned DW_PER_WORD = 4;
  localparam int unsigned WORD_WIDTH  = DW_PER_WORD * DW_WIDTH;

  // Final-beat DW mask, indexed by request length [1:0]
  localparam logic [3:0] LAST_DW_VLD [4] = '{4'b1111, 4'b0001, 4'b0011, 4'b0111};

endpackage

// File: rtl/ips2l_pcie_dma_rd_ctrl_if.sv
// Bundle of the read-request, BAR RAM read and completion-stream signals.
interface ips2l_pcie_dma_rd_ctrl_if
  import pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
);
  logic                  rd_start;
  logic [9:0]            length;
  logic [63:0]           addr;
  logic [1:0]            bar_hit;
  logic                  rd_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            rd_bar_hit;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  valid;
  logic                  ready;
  logic [WORD_WIDTH-1:0] data;
  logic [3:0]            dw_vld;
  logic                  last;

  modport master (
    input  rd_start, length, addr, bar_hit, rd_data, ready,
    output rd_ready, rd_en, rd_addr, rd_bar_hit, valid, data, dw_vld, last
  );

  modport slave (
    output rd_start, length, addr, bar_hit, rd_data, ready,
    input  rd_ready, rd_en, rd_addr, rd_bar_hit, valid, data, dw_vld, last
  );
endinterface

// File: rtl/pcie_dma_rd_fifo.sv
// 4x128 word FIFO exposing the head and the entry behind it for beat assembly.
module pcie_dma_rd_fifo
  import pcie_dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clr,
  output logic [WORD_WIDTH-1:0] head,
  output logic [WORD_WIDTH-1:0] next,
  output logic [CNT_W-1:0]      count
);
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      rptr_nxt;

  assign rptr_nxt = rptr + 1'b1;
  assign head     = mem[rptr];
  assign next     = mem[rptr_nxt];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr_nxt;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/ips2l_pcie_dma_rd_ctrl.sv
// Reads a DW-aligned request from BAR RAM and repacks it into 128-bit completion beats.
module ips2l_pcie_dma_rd_ctrl
  import pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_start,
  input  logic [9:0]            i_length,
  input  logic [63:0]           i_addr,
  input  logic [1:0]            i_bar_hit,
  output logic                  o_rd_ready,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [1:0]            o_rd_bar_hit,
  input  logic [WORD_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic [3:0]            o_dw_vld,
  output logic                  o_last
);
  rd_state_e               state;
  logic [1:0]              off;
  logic [1:0]              len_lo;
  logic [10:0]             words_total;
  logic [10:0]             beats_total;
  logic [10:0]             rd_cnt;
  logic [10:0]             beat_cnt;
  logic [10:0]             req_len;
  logic                    pend;
  logic                    accept;
  logic                    beat_take;
  logic                    last_beat;
  logic                    last_word;
  logic                    fifo_pop;
  logic                    fifo_clr;
  logic [3:0]              occ;
  logic [CNT_W-1:0]        fifo_count;
  logic [WORD_WIDTH-1:0]   fifo_head;
  logic [WORD_WIDTH-1:0]   fifo_next;
  logic [2*WORD_WIDTH-1:0] pair;
  logic [WORD_WIDTH-1:0]   beat_data;
  logic                    unused_addr;

  assign unused_addr = ^{i_addr[63:ADDR_WIDTH+4], i_addr[1:0]};

  assign accept    = i_rd_start & o_rd_ready;
  assign req_len   = (i_length == '0) ? 11'd1024 : {1'b0, i_length};
  assign last_word = (beat_cnt + 11'd1 == words_total);
  assign last_beat = (beat_cnt + 11'd1 == beats_total);

  // Beat k needs word k at the head plus word k+1, unless word k is the final one
  assign o_valid   = (state != ST_IDLE) && (fifo_count != '0) &&
                     ((fifo_count >= CNT_W'(2)) || last_word);
  assign beat_take = o_valid & i_ready;
  assign fifo_pop  = beat_take & ~last_beat;
  assign fifo_clr  = beat_take & last_beat;

  assign pair      = {(last_word ? {WORD_WIDTH{1'b0}} : fifo_next), fifo_head};
  assign beat_data = WORD_WIDTH'(pair >> {off, 5'd0});
  assign o_data    = o_valid ? beat_data : '0;
  assign o_last    = o_valid & last_beat;
  assign o_dw_vld  = !o_valid ? 4'b0000 : (last_beat ? LAST_DW_VLD[len_lo] : 4'b1111);

  // Occupancy after this edge: stored + landing + still in RAM - leaving
  assign occ = {1'b0, fifo_count} + {3'b0, pend} + {3'b0, o_rd_en} - {3'b0, fifo_pop};

  pcie_dma_rd_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (i_rd_data),
    .pop       (fifo_pop),
    .clr       (fifo_clr),
    .head      (fifo_head),
    .next      (fifo_next),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      o_rd_ready   <= 1'b1;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_bar_hit <= '0;
      pend         <= 1'b0;
      off          <= '0;
      len_lo       <= '0;
      words_total  <= '0;
      beats_total  <= '0;
      rd_cnt       <= '0;
      beat_cnt     <= '0;
    end else begin
      pend <= o_rd_en;
      if (o_rd_en)   o_rd_addr <= o_rd_addr + 1'b1;
      if (beat_take) beat_cnt  <= beat_cnt + 11'd1;
      case (state)
        ST_IDLE: begin
          o_rd_en <= 1'b0;
          if (accept) begin
            // First read is issued straight from the accept edge
            state        <= ST_READ;
            o_rd_ready   <= 1'b0;
            o_rd_en      <= 1'b1;
            rd_cnt       <= 11'd1;
            o_rd_addr    <= i_addr[ADDR_WIDTH+3:4];
            o_rd_bar_hit <= i_bar_hit;
            off          <= i_addr[3:2];
            len_lo       <= i_length[1:0];
            words_total  <= (req_len + {9'b0, i_addr[3:2]} + 11'd3) >> 2;
            beats_total  <= (req_len + 11'd3) >> 2;
            beat_cnt     <= '0;
          end
        end
        ST_READ: begin
          if (rd_cnt == words_total) begin
            state   <= ST_DRAIN;
            o_rd_en <= 1'b0;
          end else if (occ < 4'd4) begin
            o_rd_en <= 1'b1;
            rd_cnt  <= rd_cnt + 11'd1;
          end else begin
            o_rd_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          o_rd_en <= 1'b0;
          if (beat_take && last_beat) begin
            state      <= ST_IDLE;
            o_rd_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_rd_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/ips2l_pcie_dma_rd_ctrl.md
IPS2L_PCIE_DMA_RD_CTRL -- requirements
Module: ips2l_pcie_dma_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: BAR RAM word-address width, one word = 128 bits.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_rd_start  in  1  one-cycle read-request strobe.
- i_length  in  10  request length in DW; 0 = 1024.
- i_addr  in  64  request byte address.
- i_bar_hit  in  2  target BAR.
- o_rd_ready  out  1  high when idle and able to accept a request.
- o_rd_en  out  1  RAM read strobe.
- o_rd_addr  out  ADDR_WIDTH  RAM word address.
- o_rd_bar_hit  out  2  BAR select held for the whole request.
- i_rd_data  in  128  RAM data, valid exactly 1 cycle after o_rd_en; DW lane n = bits 32n+31:32n.
- o_valid  out  1  completion data beat valid.
- i_ready  in  1  downstream accept.
- o_data  out  128  packed completion data; first DW in lane 0.
- o_dw_vld  out  4  valid-DW mask of the beat.
- o_last  out  1  final beat of the request.

Function
REQ-003 SHALL accept a request only when i_rd_start=1 and o_rd_ready=1; i_rd_start while busy SHALL be ignored with no side effect.
REQ-004 On accept SHALL latch: off=i_addr[3:2], L=i_length (0→1024), start word=i_addr[ADDR_WIDTH+3:4], bar_hit; o_rd_ready SHALL drop the next cycle.
REQ-005 SHALL compute total RAM words W=(L+off+3)>>2 and output beats B=(L+3)>>2 in 11-bit arithmetic; W SHALL be B or B+1.
REQ-006 SHALL use states IDLE→READ (on accept)→DRAIN (after the W-th o_rd_en)→IDLE (when the beat with o_last is accepted).
REQ-007 SHALL assert o_rd_en only in READ and only when words in the FIFO plus reads in flight is less than 4; it SHALL issue exactly W reads.
REQ-008 o_rd_addr SHALL start at the start word and increment by 1 after each o_rd_en, wrapping modulo 2^ADDR_WIDTH.
REQ-009 Returned words SHALL enter a 4-entry FIFO; it SHALL never overflow.
REQ-010 Beat k SHALL equal DWs off+4k..off+4k+3 taken from {word k+1, word k} shifted right by 32*off; upper lanes beyond W SHALL be zero.
REQ-011 o_valid for beat k SHALL assert when word k is at the FIFO head and either word k+1 is also present or k+1=W.
REQ-012 Word k SHALL be popped when beat k is accepted (o_valid & i_ready); the last word when W=B+1 SHALL be popped with beat B-1.
REQ-013 o_dw_vld SHALL be 4'b1111 on non-final beats; on the final beat, by L[1:0]: 0→1111, 1→0001, 2→0011, 3→0111.
REQ-014 o_data, o_dw_vld and o_last SHALL hold stable while o_valid=1 and i_ready=0.
REQ-015 With i_ready held high, throughput SHALL be 1 beat/cycle after the first beat.
REQ-016 First o_valid SHALL come no later than cycle 4 after the accept cycle 0: o_rd_en at cycle 1, data at cycle 2.
REQ-017 o_rd_ready SHALL return high the cycle after the o_last beat is accepted; a request in that cycle SHALL be accepted.
REQ-018 A 1024-DW request from any offset SHALL complete without counter overflow.

Reset
REQ-019 While rst_n=0 SHALL hold state IDLE, FIFO empty, counters 0, o_rd_ready=1 after release, and o_rd_en, o_rd_addr, o_rd_bar_hit, o_valid, o_data, o_dw_vld, o_last all 0.
REQ-020 Reset mid-request SHALL abort it immediately; no beat of it SHALL appear after release.

Structure
REQ-021 The shared package pcie_dma_pkg SHALL hold the state encoding, FIFO depth 4, DW width 32 and the final-beat dw_vld table.
REQ-022 The FIFO SHALL be a sub-module pcie_dma_rd_fifo (4x128, push/pop, count output).

Verification
REQ-023 L=1, addr=0x0, i_ready=1 → 1 read; one beat, o_dw_vld=0001, o_last=1, o_data[31:0]=RAM[0][31:0].
REQ-024 L=6, addr=0xC (off=3) → reads at words 0,1,2; beat0 = RAM0.DW3,RAM1.DW0-2 with o_dw_vld 1111; beat1 = RAM1.DW3,RAM2.DW0 with o_dw_vld 0011 and o_last=1.
REQ-025 L=0 (1024 DW), off=1, i_ready=1 → 257 reads, 256 beats, last o_dw_vld=1111, o_last only on beat 255, no FIFO overflow.
REQ-026 L=16, i_ready toggled 1/0 every cycle → beats unchanged while stalled, never more than 4 reads outstanding, 4 beats total.
REQ-027 Start word 511, L=8, off=0 → o_rd_addr sequence 511, 0; i_rd_start while busy ignored; rst_n pulsed mid-burst → outputs 0, o_rd_ready=1 after release.
